mem_stage: RTL and testbench

Memory-access stage of the pipelined RV32 core. It sits between the EX/MEM pipeline register and the writeback mux. It consumes the M-stage control and data, drives a valid/ack data-memory port with byte-lane steering, and stalls the pipeline while an access is outstanding. Load data is aligned and sign- or zero-extended, and everything is registered into the MEM/WB pipeline outputs.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_if.sv | 25 ++
 rtl/mem_align.sv | 73 +++++++
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   - memctrl codes (RISC-V load/store funct3 encoding)
//   - FSM state type for the data-memory handshake
//   - access_ok(): alignment/legality check for one memctrl/offset pair
package mem_pkg;

  localparam logic [2:0] MC_B  = 3'b000;
  localparam logic [2:0] MC_H  = 3'b001;
  localparam logic [2:0] MC_W  = 3'b010;
  localparam logic [2:0] MC_BU = 3'b100;
  localparam logic [2:0] MC_HU = 3'b101;

  localparam int LANES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // True when the access size is legal and naturally aligned at this offset.
  function automatic logic access_ok(input logic [2:0] mc, input logic [1:0] off);
    logic ok;
    case (mc)
      MC_B, MC_BU: ok = 1'b1;
      MC_H, MC_HU: ok = ~off[0];
      MC_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_if.sv
// mem_if: valid/ack data-memory port.
//   master (pipeline side): req, we, addr, be, wdata out; ack, rdata in
//   slave  (memory side)  : the mirror image
// rdata is only meaningful in a cycle where ack is high.
interface mem_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata;
  logic             ack;
  logic [WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_align.sv
// mem_align: purely combinational byte-lane logic for the memory stage.
//   memctrl   in  3      funct3 of the load/store
//   memop     in  1      a load or store is present
//   is_store  in  1      access is a write (wins over read)
//   addr_lo   in  2      byte offset within the word
//   wdata_in  in  WIDTH  store data from the register file
//   rdata     in  WIDTH  word returned by memory
//   be        out 4      byte enables (all ones for loads)
//   wdata     out WIDTH  store data replicated onto every lane
//   load_data out WIDTH  extracted and extended load value
//   bad       out 1      illegal or misaligned access
// Only WIDTH=32 is meaningful: the lane logic is fixed at four bytes.
module mem_align
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       memctrl,
  input  logic             memop,
  input  logic             is_store,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] wdata_in,
  input  logic [WIDTH-1:0] rdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic             bad
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign bad = memop & ~access_ok(memctrl, addr_lo);

  // Replication means the memory can take any lane without a shifter:
  // lane gi carries byte 0 (SB), byte gi%2 (SH) or byte gi (SW).
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      always_comb begin
        case (memctrl[1:0])
          2'b00:   wdata[8*gi +: 8] = wdata_in[7:0];
          2'b01:   wdata[8*gi +: 8] = wdata_in[8*(gi%2) +: 8];
          default: wdata[8*gi +: 8] = wdata_in[8*gi +: 8];
        endcase
      end
    end
  endgenerate

  always_comb begin
    be = 4'b1111;
    if (is_store) begin
      case (memctrl[1:0])
        2'b00:   be = 4'b0001 << addr_lo;
        2'b01:   be = 4'b0011 << addr_lo;
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = rdata[16*addr_lo[1] +: 16];
    case (memctrl)
      MC_B:    load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      MC_BU:   load_data = {{(WIDTH-8){1'b0}}, byte_sel};
      MC_H:    load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      MC_HU:   load_data = {{(WIDTH-16){1'b0}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the pipelined RV32 core.
//   clk, rst_n            clock, asynchronous active-low reset
//   *M inputs             M-stage control/data from the EX/MEM register
//   dmem (mem_if.master)  valid/ack data-memory port with byte steering
//   stallM                holds PC, IF/ID, ID/EX, EX/MEM while an access waits
//   *W outputs            MEM/WB pipeline register; excW flags a bad access
// The bus request is a function of the held M inputs, so address, enables
// and data stay stable for as long as the access is outstanding.
module mem_stage
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             regwriteM,
  input  logic [1:0]       resultsrcM,
  input  logic             memwriteM,
  input  logic             memreadM,
  input  logic [2:0]       memctrlM,
  input  logic [WIDTH-1:0] aluresultM,
  input  logic [WIDTH-1:0] writedataM,
  input  logic [4:0]       rdM,
  input  logic [WIDTH-1:0] pcplus4M,
  mem_if.master            dmem,
  output logic             stallM,
  output logic             regwriteW,
  output logic [1:0]       resultsrcW,
  output logic [4:0]       rdW,
  output logic [WIDTH-1:0] aluresultW,
  output logic [WIDTH-1:0] readdataW,
  output logic [WIDTH-1:0] pcplus4W,
  output logic             excW
);

  state_t           state_reg, state_next;
  logic             memop;
  logic             bad;
  logic             load_en;
  logic             req;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] load_data;

  assign memop   = memreadM | memwriteM;
  // A simultaneous read+write is a store, so it never returns load data.
  assign load_en = memreadM & ~memwriteM & ~bad;

  mem_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .memctrl   (memctrlM),
    .memop     (memop),
    .is_store  (memwriteM),
    .addr_lo   (aluresultM[1:0]),
    .wdata_in  (writedataM),
    .rdata     (dmem.rdata),
    .be        (be),
    .wdata     (wdata),
    .load_data (load_data),
    .bad       (bad)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req && !dmem.ack) state_next = BUSY;
      BUSY:    if (dmem.ack)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // rst_n gates the request so it drops together with the state when reset
  // hits mid-access, even though the M inputs are still being held.
  always_comb begin
    req    = rst_n & memop & ~bad;
    stallM = req & ~dmem.ack;
  end

  assign dmem.req   = req;
  assign dmem.we    = memwriteM;
  assign dmem.addr  = {aluresultM[WIDTH-1:2], 2'b00};
  assign dmem.be    = be;
  assign dmem.wdata = wdata;

  // ---------------- MEM/WB register ----------------
  // A stall cycle inserts a bubble: only the write-enable and exception
  // flag are forced low, the data fields simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwriteW  <= 1'b0;
      resultsrcW <= '0;
      rdW        <= '0;
      aluresultW <= '0;
      readdataW  <= '0;
      pcplus4W   <= '0;
      excW       <= 1'b0;
    end else if (stallM) begin
      regwriteW  <= 1'b0;
      excW       <= 1'b0;
    end else begin
      regwriteW  <= regwriteM & ~bad;
      resultsrcW <= resultsrcM;
      rdW        <= rdM;
      aluresultW <= aluresultM;
      readdataW  <= load_en ? load_data : '0;
      pcplus4W   <= pcplus4M;
      excW       <= bad;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test-plan cases followed by randomized load/store/ALU
// traffic, all checked against an arithmetic reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        regwriteM = 1'b0;
  logic [1:0]  resultsrcM = '0;
  logic        memwriteM = 1'b0;
  logic        memreadM = 1'b0;
  logic [2:0]  memctrlM = '0;
  logic [31:0] aluresultM = '0;
  logic [31:0] writedataM = '0;
  logic [4:0]  rdM = '0;
  logic [31:0] pcplus4M = '0;
  logic        stallM;
  logic        regwriteW;
  logic [1:0]  resultsrcW;
  logic [4:0]  rdW;
  logic [31:0] aluresultW;
  logic [31:0] readdataW;
  logic [31:0] pcplus4W;
  logic        excW;

  int n_cmp = 0;
  int n_err = 0;

  mem_if #(.WIDTH(32)) dmem_bus ();

  mem_stage #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .regwriteM  (regwriteM),
    .resultsrcM (resultsrcM),
    .memwriteM  (memwriteM),
    .memreadM   (memreadM),
    .memctrlM   (memctrlM),
    .aluresultM (aluresultM),
    .writedataM (writedataM),
    .rdM        (rdM),
    .pcplus4M   (pcplus4M),
    .dmem       (dmem_bus),
    .stallM     (stallM),
    .regwriteW  (regwriteW),
    .resultsrcW (resultsrcW),
    .rdW        (rdW),
    .aluresultW (aluresultW),
    .readdataW  (readdataW),
    .pcplus4W   (pcplus4W),
    .excW       (excW)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int access_bytes(input logic [2:0] mc);
    int n;
    case (mc)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;     // no such size
    endcase
    return n;
  endfunction

  function automatic logic model_bad(input logic [2:0] mc, input logic [31:0] addr);
    int n;
    n = access_bytes(mc);
    if (n == 0) return 1'b1;
    return (addr % n) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic is_store, input logic [2:0] mc, input logic [31:0] addr);
    int n;
    if (!is_store) return 4'hF;
    n = access_bytes(mc);
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] mc, input logic [31:0] d);
    case (access_bytes(mc))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] mc, input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] v;
    case (access_bytes(mc))
      1: begin
        v = (w >> (8 * (addr % 4))) & 32'hFF;
        if (mc == 3'd0 && v >= 32'h80) v = v - 32'h100;
      end
      2: begin
        v = (w >> (8 * (addr & 2))) & 32'hFFFF;
        if (mc == 3'd1 && v >= 32'h8000) v = v - 32'h1_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One instruction in the M stage; memory acks `delay` cycles after the
  // request cycle. Entered and left just after a rising edge.
  task automatic run_op(input string tag, input logic rw, input logic [1:0] rs,
                        input logic mw, input logic mr, input logic [2:0] mc,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        input logic [31:0] pc, input int delay);
    logic memop, bad, exp_req, last;
    int   waits;
    memop   = mr | mw;
    bad     = memop && model_bad(mc, addr);
    exp_req = memop && !bad;
    waits   = exp_req ? delay : 0;

    regwriteM = rw; resultsrcM = rs; memwriteM = mw; memreadM = mr;
    memctrlM = mc; aluresultM = addr; writedataM = wd; rdM = rd; pcplus4M = pc;

    for (int i = 0; i <= waits; i++) begin
      last = (i == waits);
      // An ack without a request must be ignored, so sometimes send one.
      dmem_bus.ack   = last ? (exp_req ? 1'b1 : 1'($urandom % 2)) : 1'b0;
      dmem_bus.rdata = last ? rdata : $urandom;
      #1;
      check_val($sformatf("%s.req", tag), 32'(dmem_bus.req), 32'(exp_req));
      check_val($sformatf("%s.stall", tag), 32'(stallM), 32'(exp_req && !last));
      if (exp_req) begin
        check_val($sformatf("%s.addr", tag), dmem_bus.addr, addr & 32'hFFFF_FFFC);
        check_val($sformatf("%s.we", tag), 32'(dmem_bus.we), 32'(mw));
        check_val($sformatf("%s.be", tag), 32'(dmem_bus.be), 32'(model_be(mw, mc, addr)));
        if (mw) check_val($sformatf("%s.wdata", tag), dmem_bus.wdata, model_wdata(mc, wd));
      end
      @(posedge clk);
      #1;
      if (!last) begin
        check_val($sformatf("%s.bubble_rw", tag), 32'(regwriteW), 32'd0);
        check_val($sformatf("%s.bubble_exc", tag), 32'(excW), 32'd0);
      end
    end
    dmem_bus.ack = 1'b0;

    check_val($sformatf("%s.regwriteW", tag), 32'(regwriteW), 32'(rw && !bad));
    check_val($sformatf("%s.excW", tag), 32'(excW), 32'(bad));
    check_val($sformatf("%s.resultsrcW", tag), 32'(resultsrcW), 32'(rs));
    check_val($sformatf("%s.rdW", tag), 32'(rdW), 32'(rd));
    check_val($sformatf("%s.aluresultW", tag), aluresultW, addr);
    check_val($sformatf("%s.pcplus4W", tag), pcplus4W, pc);
    check_val($sformatf("%s.readdataW", tag), readdataW,
              (mr && !mw && !bad) ? model_load(mc, addr, rdata) : 32'd0);
    $display("op %-8s mc=%0d rd=%0b wr=%0b addr=%h delay=%0d bad=%0b", tag, mc, mr, mw, addr, waits, bad);
  endtask

  task automatic check_w_zero(input string tag);
    check_val($sformatf("%s.regwriteW", tag), 32'(regwriteW), 32'd0);
    check_val($sformatf("%s.excW", tag), 32'(excW), 32'd0);
    check_val($sformatf("%s.resultsrcW", tag), 32'(resultsrcW), 32'd0);
    check_val($sformatf("%s.rdW", tag), 32'(rdW), 32'd0);
    check_val($sformatf("%s.aluresultW", tag), aluresultW, 32'd0);
    check_val($sformatf("%s.readdataW", tag), readdataW, 32'd0);
    check_val($sformatf("%s.pcplus4W", tag), pcplus4W, 32'd0);
  endtask

  initial begin
    dmem_bus.ack   = 1'b0;
    dmem_bus.rdata = '0;

    // Reset state
    #2;
    check_val("rst.req", 32'(dmem_bus.req), 32'd0);
    check_val("rst.stall", 32'(stallM), 32'd0);
    check_w_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed test-plan cases
    run_op("sw", 1'b0, 2'd0, 1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 5'd0, 32'h4, 0);
    run_op("sb", 1'b0, 2'd0, 1'b1, 1'b0, 3'b000, 32'h103, 32'h000000A5, 32'h0, 5'd0, 32'h8, 0);
    run_op("lb", 1'b1, 2'd1, 1'b0, 1'b1, 3'b000, 32'h102, 32'h0, 32'h12F03456, 5'd7, 32'hC, 3);
    check_val("lb.plan", readdataW, 32'hFFFFFFF0);
    run_op("lbu", 1'b1, 2'd1, 1'b0, 1'b1, 3'b100, 32'h102, 32'h0, 32'h12F03456, 5'd8, 32'h10, 0);
    check_val("lbu.plan", readdataW, 32'h000000F0);
    run_op("lh_mis", 1'b1, 2'd1, 1'b0, 1'b1, 3'b001, 32'h101, 32'h0, 32'h0, 5'd9, 32'h14, 2);
    check_val("lh_mis.exc", 32'(excW), 32'd1);
    run_op("mc011", 1'b1, 2'd1, 1'b0, 1'b1, 3'b011, 32'h101, 32'h0, 32'h0, 5'd9, 32'h18, 2);
    run_op("sh_hi", 1'b0, 2'd0, 1'b1, 1'b0, 3'b001, 32'h206, 32'h0000BEEF, 32'h0, 5'd0, 32'h1C, 1);
    run_op("rw_both", 1'b1, 2'd1, 1'b1, 1'b1, 3'b010, 32'h300, 32'h01234567, 32'h89ABCDEF, 5'd3, 32'h20, 2);

    // Reset in the middle of an outstanding load
    regwriteM = 1'b1; resultsrcM = 2'd1; memwriteM = 1'b0; memreadM = 1'b1;
    memctrlM = 3'b010; aluresultM = 32'h400; rdM = 5'd5; pcplus4M = 32'h24;
    dmem_bus.ack = 1'b0;
    #1;
    check_val("rstbusy.req_pre", 32'(dmem_bus.req), 32'd1);
    @(posedge clk); #2;
    check_val("rstbusy.stall_pre", 32'(stallM), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rstbusy.req", 32'(dmem_bus.req), 32'd0);
    check_val("rstbusy.stall", 32'(stallM), 32'd0);
    check_w_zero("rstbusy");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("alu55", 1'b1, 2'd0, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 32'h0, 5'd1, 32'h28, 0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      int kind;
      logic mr, mw;
      kind = int'($urandom % 4);
      mr = (kind == 1) || (kind == 3);
      mw = (kind == 2) || (kind == 3);
      run_op($sformatf("rnd%0d", n), 1'($urandom), 2'($urandom), mw, mr, 3'($urandom),
             $urandom, $urandom, $urandom, 5'($urandom), $urandom, int'($urandom % 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
